i2c_slave_regs: RTL and testbench
=================================

I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h76, the 7-bit device address this responder ACKs.
REQ-002 SHALL have port clk, input, 1, system clock; one clock domain only.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port i2c_scl, input, 1, I2C SCL from the master.
REQ-005 SHALL have port i2c_sda, inout, 1, I2C SDA; the block drives only 1'b0 or 1'bz, never 1'b1.
REQ-006 SHALL have port reg_addr, output, 8, register pointer.
REQ-007 SHALL have port reg_wdata, output, 8, write data, valid while reg_wr is high.
REQ-008 SHALL have port reg_wr, output, 1, one-clk write strobe.
REQ-009 SHALL have port reg_rdata, input, 8, read data for reg_addr; sampled by the block.
REQ-010 SHALL have port busy, output, 1, high from a START accepted by the block until the next STOP.

Function
REQ-011 SHALL pass i2c_scl and i2c_sda through 2-FF synchronizers and detect edges on the synchronized values; clk SHALL be at least 20x the SCL rate.
REQ-012 SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high; both are valid in any state, and a repeated START is supported.
REQ-013 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-014 START from any state SHALL go to ADDR, clear the bit counter and set busy; STOP from any state SHALL go to IDLE, release SDA and clear busy.
REQ-015 SHALL sample data bits on SCL rising edges, MSB first; 8 bits form one byte.
REQ-016 When the 8th SCL falling edge follows a matching address, SHALL drive SDA low for exactly the 9th SCL clock and release it on the 9th SCL falling edge; ACK_x states follow this timing.
REQ-017 Address mismatch SHALL leave SDA released and go to IDLE; SDA stays released and reg_wr stays low until the next START.
REQ-018 After an address with R/W=0, the first data byte SHALL load reg_addr and be ACKed (PTR -> PTR_ACK -> WDATA).
REQ-019 Each later write byte SHALL be ACKed, and at the 8th SCL falling edge SHALL set reg_wdata and pulse reg_wr for one clk with the current reg_addr; reg_addr SHALL increment on the next clk, wrapping 8'hFF -> 8'h00.
REQ-020 After an address with R/W=1, SHALL latch reg_rdata into a shift register at the SCL falling edge that ends ADDR_ACK, then drive bits on SCL falling edges (a 0 bit drives low, a 1 bit releases SDA).
REQ-021 After 8 read bits, SHALL release SDA and sample the master ACK on the 9th SCL rising edge.
REQ-022 A master ACK SHALL increment reg_addr (with wrap) and load the next reg_rdata at the 9th SCL falling edge.
REQ-023 A master NACK SHALL go to IDLE with SDA released, with busy held until STOP.
REQ-024 A STOP or START arriving mid-byte SHALL discard the partial byte and SHALL NOT pulse reg_wr.
REQ-025 reg_addr SHALL persist across transactions, so a read without a pointer write continues from the last pointer.

Reset
REQ-026 While rst_n is low: state IDLE, SDA released (z), reg_addr=8'h00, reg_wdata=8'h00, reg_wr=0, busy=0, synchronizers=1.
REQ-027 Reset asserted mid-transaction SHALL release SDA immediately (asynchronously); after release the block SHALL ignore the bus until a new START.

Verification
REQ-028 Write 0xEC, 0xF4, 0x55 then STOP -> three ACKs; exactly one reg_wr pulse with reg_addr=0xF4, reg_wdata=0x55; afterwards reg_addr=0xF5 and busy=0.
REQ-029 Write 0xEC, 0xFF, 0x11, 0x22 -> writes (0xFF,0x11) then (0x00,0x22); final reg_addr=0x01.
REQ-030 Write 0xEC, 0x88, repeated START, 0xED, read 2 bytes (ACK, then NACK), with a memory model on reg_rdata -> bus returns mem[0x88] then mem[0x89]; SDA is released after the NACK.
REQ-031 Address byte 0xEE (0x77) -> SDA high on the 9th clock, no reg_wr, busy=1 until STOP.
REQ-032 STOP after 4 bits of a write data byte -> no reg_wr; the next valid transaction completes normally.
REQ-033 rst_n pulsed low while driving a read 0 bit -> SDA becomes z within the reset pulse and reg_addr=0x00; a following write of 0xEC, 0x10, 0xAA -> one reg_wr at 0x10.

Source files
------------

// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: I2C register-access responder.
//
// Acts as an I2C slave at address DEV_ADDR and bridges bus transfers onto a simple
// register port.
// - Write transfer: the first data byte loads the register pointer. Each later byte
//   produces a one-clk reg_wr strobe, after which the pointer post-increments.
// - Read transfer: bytes are shifted out of reg_rdata, starting at the current pointer.
//   Each master ACK advances the pointer.
// The pointer persists across transactions.
//
// Ports:
//   clk        system clock (at least 20x the SCL rate)
//   rst_n      asynchronous active-low reset
//   i2c_scl    SCL from the master
//   i2c_sda    open-drain SDA (driven 0 or z only)
//   reg_addr   register pointer
//   reg_wdata  write data, valid while reg_wr is high
//   reg_wr     one-clk write strobe
//   reg_rdata  read data for reg_addr
//   busy       high from START until STOP

module i2c_slave_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h76
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizers and bus event detection
  // ---------------------------------------------------------------------------
  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       sda_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], i2c_scl};
      sda_sync_q <= {sda_sync_q[0], i2c_sda};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  logic scl_s;
  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic bus_start;
  logic bus_stop;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  // SDA may only change while SCL is low, except for START and STOP.
  assign bus_start = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign bus_stop  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  // ---------------------------------------------------------------------------
  // Protocol state
  // ---------------------------------------------------------------------------
  state_e     state_q,  state_d;
  logic [3:0] cnt_q,    cnt_d;     // SCL rising edges seen in the current byte
  logic [7:0] rx_q,     rx_d;      // receive shift register
  logic [7:0] tx_q,     tx_d;      // transmit shift register, bit 7 is on the bus
  logic       oe_q,     oe_d;      // 1: pull SDA low
  logic       rw_q,     rw_d;      // R/W bit of the accepted address
  logic       mack_q,   mack_d;    // master acknowledged the last read byte
  logic       load_q,   load_d;    // fetch reg_rdata one clk after a pointer bump
  logic       busy_q,   busy_d;
  logic [7:0] addr_q,   addr_d;
  logic [7:0] wdata_q,  wdata_d;
  logic       wr_q,     wr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rx_q    <= 8'h00;
      tx_q    <= 8'h00;
      oe_q    <= 1'b0;
      rw_q    <= 1'b0;
      mack_q  <= 1'b0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      oe_q    <= oe_d;
      rw_q    <= rw_d;
      mack_q  <= mack_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    oe_d    = oe_q;
    rw_d    = rw_q;
    mack_d  = mack_q;
    load_d  = 1'b0;
    busy_d  = busy_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;

    // Pointer post-increment on the clk after a write strobe.
    if (wr_q) begin
      addr_d = addr_q + 8'd1;
    end

    // reg_rdata now reflects the bumped pointer; put its MSB on the bus.
    if (load_q) begin
      tx_d = reg_rdata;
      oe_d = ~reg_rdata[7];
    end

    if (bus_start) begin
      state_d = StAddr;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b1;
    end else if (bus_stop) begin
      state_d = StIdle;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          oe_d = 1'b0;
        end

        StAddr: begin
          if (scl_rise) begin
            rx_d  = {rx_q[6:0], sda_s};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (rx_q[7:1] == DEV_ADDR) begin
              oe_d    = 1'b1;
              rw_d    = rx_q[0];
              state_d = StAddrAck;
            end else begin
              state_d = StIdle;
            end
          end
        end

        StAddrAck: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            if (rw_q) begin
              tx_d    = reg_rdata;
              oe_d    = ~reg_rdata[7];
              state_d = StRdata;
            end else begin
              oe_d    = 1'b0;
              state_d = StPtr;
            end
          end
        end

        StPtr: begin
          if (scl_rise) begin
            rx_d  = {rx_q[6:0], sda_s};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            addr_d  = rx_q;
            oe_d    = 1'b1;
            state_d = StPtrAck;
          end
        end

        StPtrAck: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            cnt_d   = 4'd0;
            state_d = StWdata;
          end
        end

        StWdata: begin
          if (scl_rise) begin
            rx_d  = {rx_q[6:0], sda_s};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            wdata_d = rx_q;
            wr_d    = 1'b1;
            oe_d    = 1'b1;
            state_d = StWdataAck;
          end
        end

        StWdataAck: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            cnt_d   = 4'd0;
            state_d = StWdata;
          end
        end

        StRdata: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              // Hand SDA to the master for its ACK/NACK.
              oe_d    = 1'b0;
              state_d = StRdataAck;
            end else begin
              oe_d = ~tx_q[6];
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
        end

        StRdataAck: begin
          if (scl_rise) begin
            mack_d = ~sda_s;
          end else if (scl_fall) begin
            cnt_d = 4'd0;
            if (mack_q) begin
              addr_d  = addr_q + 8'd1;
              load_d  = 1'b1;
              state_d = StRdata;
            end else begin
              oe_d    = 1'b0;
              state_d = StIdle;
            end
          end
        end

        default: begin
          state_d = StIdle;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign i2c_sda   = oe_q ? 1'b0 : 1'bz;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr    = wr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Testbench for i2c_slave_regs.
// Provides a bit-banged I2C master, a register memory that is attached to the
// register port, and a reference model of the register array and pointer.

module tb_i2c_slave_regs;

  localparam int Q = 100;  // quarter SCL period; clk period is 10

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda_low = 1'b0;
  wire        sda_bus;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       reg_wr;
  logic       busy;

  pullup (sda_bus);
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

  // Register file on the DUT side, and the model's view of it.
  logic [7:0] mem     [256];
  logic [7:0] exp_mem [256];
  logic [7:0] exp_ptr;

  assign reg_rdata = mem[reg_addr];

  int checks   = 0;
  int failures = 0;

  logic [7:0] wq_addr[$];
  logic [7:0] wq_data[$];

  always #5 clk = ~clk;

  // Log every cycle with reg_wr high and apply the write to the attached memory.
  always @(posedge clk) begin
    if (reg_wr) begin
      wq_addr.push_back(reg_addr);
      wq_data.push_back(reg_wdata);
      mem[reg_addr] <= reg_wdata;
    end
  end

  i2c_slave_regs #(
    .DEV_ADDR(7'h76)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i2c_scl  (scl),
    .i2c_sda  (sda_bus),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_wr   (reg_wr),
    .reg_rdata(reg_rdata),
    .busy     (busy)
  );

  // ---------------------------------------------------------------------------
  // Bit-banged master
  // ---------------------------------------------------------------------------
  task automatic bus_start();
    m_sda_low = 1'b0; #(Q);
    scl = 1'b1;       #(Q);
    m_sda_low = 1'b1; #(Q);
    scl = 1'b0;       #(Q);
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; #(Q);
    scl = 1'b1;       #(Q);
    m_sda_low = 1'b0; #(Q);
  endtask

  task automatic put_bit(input logic b);
    m_sda_low = ~b; #(Q);
    scl = 1'b1;     #(2 * Q);
    scl = 1'b0;     #(Q);
  endtask

  task automatic get_bit(output logic b);
    m_sda_low = 1'b0; #(Q);
    scl = 1'b1;       #(Q);
    b = sda_bus;      #(Q);
    scl = 1'b0;       #(Q);
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    ack = ~b;
  endtask

  task automatic get_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(~ack);
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #(20);
    checks++;
    if (reg_addr !== 8'h00) begin
      failures++;
      $display("FAIL reset_addr: got %h want 00", reg_addr);
    end
    checks++;
    if (reg_wdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_wdata: got %h want 00", reg_wdata);
    end
    checks++;
    if (reg_wr !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got wr=%b busy=%b want 0 0", reg_wr, busy);
    end
    checks++;
    if (sda_bus !== 1'b1) begin
      failures++;
      $display("FAIL reset_sda: got %b want 1", sda_bus);
    end
    rst_n = 1'b1;
    #(Q);
    exp_ptr = 8'h00;
  endtask

  task automatic test_write_basic();
    logic a0, a1, a2;
    clear_log();
    bus_start();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL wr_busy_start: got %b want 1", busy);
    end
    put_byte(8'hEC, a0);
    put_byte(8'hF4, a1);
    put_byte(8'h55, a2);
    bus_stop();
    #(Q);
    exp_mem[8'hF4] = 8'h55;
    exp_ptr = 8'hF5;
    checks++;
    if ({a0, a1, a2} !== 3'b111) begin
      failures++;
      $display("FAIL wr_acks: got %b want 111", {a0, a1, a2});
    end
    checks++;
    if (wq_addr.size() != 1) begin
      failures++;
      $display("FAIL wr_count: got %0d want 1", wq_addr.size());
    end else begin
      checks++;
      if (wq_addr[0] !== 8'hF4 || wq_data[0] !== 8'h55) begin
        failures++;
        $display("FAIL wr_entry: got %h/%h want f4/55", wq_addr[0], wq_data[0]);
      end
    end
    checks++;
    if (reg_addr !== exp_ptr || busy !== 1'b0) begin
      failures++;
      $display("FAIL wr_after: got addr=%h busy=%b want %h 0", reg_addr, busy, exp_ptr);
    end
  endtask

  task automatic test_wrap();
    logic ack;
    clear_log();
    bus_start();
    put_byte(8'hEC, ack);
    put_byte(8'hFF, ack);
    put_byte(8'h11, ack);
    put_byte(8'h22, ack);
    bus_stop();
    #(Q);
    exp_mem[8'hFF] = 8'h11;
    exp_mem[8'h00] = 8'h22;
    exp_ptr = 8'h01;
    checks++;
    if (wq_addr.size() != 2) begin
      failures++;
      $display("FAIL wrap_count: got %0d want 2", wq_addr.size());
    end else begin
      checks++;
      if (wq_addr[0] !== 8'hFF || wq_data[0] !== 8'h11 ||
          wq_addr[1] !== 8'h00 || wq_data[1] !== 8'h22) begin
        failures++;
        $display("FAIL wrap_entries: got %h/%h %h/%h want ff/11 00/22",
                 wq_addr[0], wq_data[0], wq_addr[1], wq_data[1]);
      end
    end
    checks++;
    if (reg_addr !== exp_ptr) begin
      failures++;
      $display("FAIL wrap_ptr: got %h want %h", reg_addr, exp_ptr);
    end
  endtask

  task automatic test_read_sr();
    logic       ack;
    logic [7:0] d0, d1;
    bus_start();
    put_byte(8'hEC, ack);
    put_byte(8'h88, ack);
    bus_start();
    put_byte(8'hED, ack);
    checks++;
    if (ack !== 1'b1) begin
      failures++;
      $display("FAIL rd_addr_ack: got %b want 1", ack);
    end
    get_byte(d0, 1'b1);
    get_byte(d1, 1'b0);
    exp_ptr = 8'h89;
    checks++;
    if (d0 !== exp_mem[8'h88] || d1 !== exp_mem[8'h89]) begin
      failures++;
      $display("FAIL rd_data: got %h %h want %h %h", d0, d1, exp_mem[8'h88], exp_mem[8'h89]);
    end
    m_sda_low = 1'b0;
    #(Q);
    checks++;
    if (sda_bus !== 1'b1) begin
      failures++;
      $display("FAIL rd_nack_release: got %b want 1", sda_bus);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rd_busy_hold: got %b want 1", busy);
    end
    bus_stop();
    #(Q);
    checks++;
    if (reg_addr !== exp_ptr || busy !== 1'b0) begin
      failures++;
      $display("FAIL rd_after: got addr=%h busy=%b want %h 0", reg_addr, busy, exp_ptr);
    end
  endtask

  task automatic test_mismatch();
    logic ack;
    clear_log();
    bus_start();
    put_byte(8'hEE, ack);
    checks++;
    if (ack !== 1'b0) begin
      failures++;
      $display("FAIL nomatch_ack: got ack=%b want 0", ack);
    end
    put_byte(8'h3C, ack);
    checks++;
    if (ack !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL nomatch_follow: got ack=%b busy=%b want 0 1", ack, busy);
    end
    bus_stop();
    #(Q);
    checks++;
    if (wq_addr.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL nomatch_after: got writes=%0d busy=%b want 0 0", wq_addr.size(), busy);
    end
  endtask

  task automatic test_partial();
    logic ack;
    clear_log();
    bus_start();
    put_byte(8'hEC, ack);
    put_byte(8'h30, ack);
    for (int i = 0; i < 4; i++) put_bit(1'($urandom));
    bus_stop();
    #(Q);
    checks++;
    if (wq_addr.size() != 0 || reg_addr !== 8'h30) begin
      failures++;
      $display("FAIL partial_discard: got writes=%0d addr=%h want 0 30",
               wq_addr.size(), reg_addr);
    end
    bus_start();
    put_byte(8'hEC, ack);
    put_byte(8'h40, ack);
    put_byte(8'h5A, ack);
    bus_stop();
    #(Q);
    exp_mem[8'h40] = 8'h5A;
    exp_ptr = 8'h41;
    checks++;
    if (wq_addr.size() != 1 || wq_addr[0] !== 8'h40 || wq_data[0] !== 8'h5A) begin
      failures++;
      $display("FAIL partial_next: got writes=%0d want one 40/5a", wq_addr.size());
    end
  endtask

  task automatic test_reset_mid_read();
    logic       ack;
    logic [7:0] p;
    p = 8'($urandom);
    mem[p] = mem[p] & 8'h7F;
    exp_mem[p] = exp_mem[p] & 8'h7F;
    bus_start();
    put_byte(8'hEC, ack);
    put_byte(p, ack);
    bus_start();
    put_byte(8'hED, ack);
    checks++;
    if (sda_bus !== 1'b0) begin
      failures++;
      $display("FAIL rst_pre_bit0: got %b want 0", sda_bus);
    end
    rst_n = 1'b0;
    #(2);
    checks++;
    if (sda_bus !== 1'b1 || reg_addr !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_async: got sda=%b addr=%h busy=%b want 1 00 0",
               sda_bus, reg_addr, busy);
    end
    #(30);
    rst_n = 1'b1;
    exp_ptr = 8'h00;
    #(Q);
    scl = 1'b1;
    #(Q);
    clear_log();
    // No START since reset: the bus must be ignored.
    put_byte(8'hEC, ack);
    put_byte(8'h10, ack);
    checks++;
    if (ack !== 1'b0 || wq_addr.size() != 0) begin
      failures++;
      $display("FAIL rst_ignore: got ack=%b writes=%0d want 0 0", ack, wq_addr.size());
    end
    bus_stop();
    bus_start();
    put_byte(8'hEC, ack);
    put_byte(8'h10, ack);
    put_byte(8'hAA, ack);
    bus_stop();
    #(Q);
    exp_mem[8'h10] = 8'hAA;
    exp_ptr = 8'h11;
    checks++;
    if (wq_addr.size() != 1 || wq_addr[0] !== 8'h10 || wq_data[0] !== 8'hAA) begin
      failures++;
      $display("FAIL rst_recover: got writes=%0d want one 10/aa", wq_addr.size());
    end
  endtask

  task automatic test_random();
    logic       ack;
    logic [7:0] p;
    logic [7:0] d;
    int         n;
    for (int it = 0; it < 4; it++) begin
      clear_log();
      p = 8'($urandom);
      n = $urandom_range(1, 4);
      bus_start();
      put_byte(8'hEC, ack);
      put_byte(p, ack);
      exp_ptr = p;
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom);
        put_byte(d, ack);
        exp_mem[exp_ptr] = d;
        exp_ptr = exp_ptr + 8'd1;
      end
      bus_stop();
      #(Q);
      checks++;
      if (wq_addr.size() != n) begin
        failures++;
        $display("FAIL rnd_wr_count[%0d]: got %0d want %0d", it, wq_addr.size(), n);
      end else begin
        for (int k = 0; k < n; k++) begin
          checks++;
          if (wq_addr[k] !== 8'(p + 8'(k)) || wq_data[k] !== exp_mem[8'(p + 8'(k))]) begin
            failures++;
            $display("FAIL rnd_wr_entry[%0d.%0d]: got %h/%h want %h/%h", it, k, wq_addr[k],
                     wq_data[k], 8'(p + 8'(k)), exp_mem[8'(p + 8'(k))]);
          end
        end
      end
      // Read continues from the pointer left by the write, no pointer byte.
      n = $urandom_range(1, 4);
      bus_start();
      put_byte(8'hED, ack);
      for (int k = 0; k < n; k++) begin
        get_byte(d, k != n - 1);
        checks++;
        if (d !== exp_mem[exp_ptr]) begin
          failures++;
          $display("FAIL rnd_rd[%0d.%0d]: got %h want %h", it, k, d, exp_mem[exp_ptr]);
        end
        if (k != n - 1) exp_ptr = exp_ptr + 8'd1;
      end
      bus_stop();
      #(Q);
      checks++;
      if (reg_addr !== exp_ptr) begin
        failures++;
        $display("FAIL rnd_ptr[%0d]: got %h want %h", it, reg_addr, exp_ptr);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      exp_mem[i] = mem[i];
    end
    exp_ptr = 8'h00;
    #(3);  // keep all sampling off the clock edges
    test_reset();
    test_write_basic();
    test_wrap();
    test_read_sr();
    test_mismatch();
    test_partial();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(900000);
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
